// File: rtl/pincfg_multi.sv
// Multi-channel step/dir pin driver: timed step pulses, direction setup delay,
// per-pin polarity, latched shutdown. `PINCFG_OVERRUN_EN builds the overrun counter at adr 4.
module pincfg_multi #(
  parameter int CHANNELS  = 2,
  parameter int DUR_WIDTH = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [CHANNELS-1:0]     step_pulse,
  input  logic [CHANNELS-1:0]     step_dir,
  output logic [2*CHANNELS-1:0]   pins_out,
  input  logic                    pin_shutdown,
  input  logic                    wb_stb_i,
  input  logic                    wb_cyc_i,
  input  logic                    wb_we_i,
  input  logic [3:0]              wb_adr_i,
  input  logic [31:0]             wb_dat_i,
  output logic [31:0]             wb_dat_o,
  output logic                    wb_ack_o
);

  typedef enum logic [1:0] {ST_IDLE, ST_SETUP, ST_PULSE} ch_state_e;

  // Wishbone: valid = cyc && stb; ready (ack) is tied high, so every access
  // completes in the cycle it is presented and writes land on the next edge.
  logic wr;
  assign wr       = wb_cyc_i && wb_stb_i && wb_we_i;
  assign wb_ack_o = 1'b1;

  logic [2*CHANNELS-1:0] polarity;
  logic [DUR_WIDTH-1:0]  step_duration;
  logic [DUR_WIDTH-1:0]  dir_setup;
  logic [1:0]            sd_sync;
  logic                  in_shutdown;
  logic [7:0]            overrun_rd;

  ch_state_e             state_q [CHANNELS];
  ch_state_e             state_d [CHANNELS];
  logic [DUR_WIDTH-1:0]  cnt_q   [CHANNELS];
  logic [DUR_WIDTH-1:0]  cnt_d   [CHANNELS];
  logic [CHANNELS-1:0]   dir_q, dir_d, go_pulse, req_drop, busy;

  always_comb begin
    for (int c = 0; c < CHANNELS; c++) begin
      state_d[c]  = state_q[c];
      cnt_d[c]    = cnt_q[c];
      dir_d[c]    = dir_q[c];
      go_pulse[c] = 1'b0;
      req_drop[c] = 1'b0;
      case (state_q[c])
        ST_IDLE: begin
          if (step_pulse[c] && !in_shutdown) begin
            if (step_dir[c] != dir_q[c]) begin
              dir_d[c] = step_dir[c];
              if (dir_setup != '0) begin
                state_d[c] = ST_SETUP;
                cnt_d[c]   = dir_setup;
              end else begin
                go_pulse[c] = 1'b1;
              end
            end else begin
              go_pulse[c] = 1'b1;
            end
          end
        end
        ST_SETUP: begin
          if (cnt_q[c] == DUR_WIDTH'(1)) go_pulse[c] = 1'b1;
          else cnt_d[c] = cnt_q[c] - DUR_WIDTH'(1);
        end
        ST_PULSE: begin
          if (cnt_q[c] == DUR_WIDTH'(1)) state_d[c] = ST_IDLE;
          else cnt_d[c] = cnt_q[c] - DUR_WIDTH'(1);
        end
        default: state_d[c] = ST_IDLE;
      endcase
      // A zero duration skips the pulse entirely.
      if (go_pulse[c]) begin
        if (step_duration == '0) begin
          state_d[c] = ST_IDLE;
        end else begin
          state_d[c] = ST_PULSE;
          cnt_d[c]   = step_duration;
        end
      end
      if (state_q[c] != ST_IDLE && step_pulse[c] && !in_shutdown) req_drop[c] = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int c = 0; c < CHANNELS; c++) begin
        state_q[c] <= ST_IDLE;
        cnt_q[c]   <= '0;
      end
      dir_q         <= '0;
      polarity      <= '0;
      step_duration <= '0;
      dir_setup     <= '0;
      sd_sync       <= '0;
      in_shutdown   <= 1'b0;
    end else begin
      for (int c = 0; c < CHANNELS; c++) begin
        state_q[c] <= state_d[c];
        cnt_q[c]   <= cnt_d[c];
      end
      dir_q   <= dir_d;
      sd_sync <= {sd_sync[0], pin_shutdown};
      if (wr && wb_adr_i == 4'd0) polarity      <= wb_dat_i[2*CHANNELS-1:0];
      if (wr && wb_adr_i == 4'd2) step_duration <= wb_dat_i[DUR_WIDTH-1:0];
      if (wr && wb_adr_i == 4'd3) dir_setup     <= wb_dat_i[DUR_WIDTH-1:0];
      // Clear beats a same-cycle set; a still-high pin re-latches next edge.
      if (wr && wb_adr_i == 4'd1) in_shutdown <= 1'b0;
      else if (sd_sync[1])        in_shutdown <= 1'b1;
    end
  end

`ifdef PINCFG_OVERRUN_EN
  logic [7:0] overrun_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                             overrun_q <= '0;
    else if (wr && wb_adr_i == 4'd4)        overrun_q <= '0;
    else if (|req_drop && overrun_q != 8'hFF) overrun_q <= overrun_q + 8'd1;
  end
  assign overrun_rd = overrun_q;
  logic unused_ok;
  assign unused_ok = ^wb_dat_i[31:16];
`else
  assign overrun_rd = 8'h00;
  logic unused_ok;
  assign unused_ok = ^{wb_dat_i[31:16], req_drop};
`endif

  always_comb begin
    for (int c = 0; c < CHANNELS; c++) begin
      busy[c]           = (state_q[c] != ST_IDLE);
      pins_out[2*c]     = polarity[2*c] ^ (state_q[c] == ST_PULSE && !in_shutdown);
      pins_out[2*c + 1] = polarity[2*c + 1] ^ dir_q[c];
    end
  end

  always_comb begin
    wb_dat_o = '0;
    case (wb_adr_i)
      4'd0:    wb_dat_o = 32'(polarity);
      4'd1:    wb_dat_o = (32'(busy) << 8) | 32'(in_shutdown);
      4'd2:    wb_dat_o = 32'(step_duration);
      4'd3:    wb_dat_o = 32'(dir_setup);
      4'd4:    wb_dat_o = 32'(overrun_rd);
      default: wb_dat_o = '0;
    endcase
  end

endmodule

// File: tb/tb_pincfg_multi.sv
// Bench for pincfg_multi: directed scenarios plus randomized traffic against a
// timestamp-based reference model (pulse windows computed from acceptance edge).
module tb_pincfg_multi;
  localparam int CH = 2;
  localparam int DW = 16;
`ifdef PINCFG_OVERRUN_EN
  localparam bit OVR_EN = 1'b1;
`else
  localparam bit OVR_EN = 1'b0;
`endif

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [CH-1:0]   step_pulse = '0;
  logic [CH-1:0]   step_dir = '0;
  logic [2*CH-1:0] pins_out;
  logic            pin_shutdown = 1'b0;
  logic            wb_stb_i = 1'b0, wb_cyc_i = 1'b0, wb_we_i = 1'b0;
  logic [3:0]      wb_adr_i = '0;
  logic [31:0]     wb_dat_i = '0;
  logic [31:0]     wb_dat_o;
  logic            wb_ack_o;

  always #5 clk = ~clk;

  pincfg_multi #(.CHANNELS(CH), .DUR_WIDTH(DW)) dut (
    .clk(clk), .rst_n(rst_n), .step_pulse(step_pulse), .step_dir(step_dir),
    .pins_out(pins_out), .pin_shutdown(pin_shutdown),
    .wb_stb_i(wb_stb_i), .wb_cyc_i(wb_cyc_i), .wb_we_i(wb_we_i),
    .wb_adr_i(wb_adr_i), .wb_dat_i(wb_dat_i), .wb_dat_o(wb_dat_o), .wb_ack_o(wb_ack_o)
  );

  int total = 0;
  int bad = 0;

  // Reference model: each accepted request is described by its acceptance edge
  // t, its setup length sp and pulse length dd; busy/active follow from n.
  int              n = 0;
  int              rst_edge = 0;
  logic [2*CH-1:0] m_pol;
  int              m_dur, m_setup, m_ovr;
  bit              m_sd;
  bit              m_dir [CH];
  int              m_t [CH], m_sp [CH], m_dd [CH];
  bit              pin_log [int];

  function automatic bit busy_at(int c, int k);
    return (k >= m_t[c]) && (k < m_t[c] + m_sp[c] + m_dd[c]);
  endfunction

  function automatic bit act_at(int c, int k);
    return (k >= m_t[c] + m_sp[c]) && (k < m_t[c] + m_sp[c] + m_dd[c]);
  endfunction

  function automatic bit all_idle();
    for (int c = 0; c < CH; c++) if (busy_at(c, n)) return 1'b0;
    return 1'b1;
  endfunction

  function automatic logic [31:0] exp_pins();
    logic [31:0] v = '0;
    for (int c = 0; c < CH; c++) begin
      v[2*c]     = m_pol[2*c] ^ (act_at(c, n) && !m_sd);
      v[2*c + 1] = m_pol[2*c + 1] ^ m_dir[c];
    end
    return v;
  endfunction

  function automatic logic [31:0] exp_reg(int adr);
    logic [31:0] v = '0;
    case (adr)
      0: v = 32'(m_pol);
      1: begin
        v[0] = m_sd;
        for (int c = 0; c < CH; c++) v[8 + c] = busy_at(c, n);
      end
      2: v = 32'(m_dur);
      3: v = 32'(m_setup);
      4: v = OVR_EN ? 32'(m_ovr) : 32'd0;
      default: v = '0;
    endcase
    return v;
  endfunction

  task automatic model_reset();
    m_pol = '0; m_dur = 0; m_setup = 0; m_ovr = 0; m_sd = 1'b0;
    for (int c = 0; c < CH; c++) begin
      m_dir[c] = 1'b0; m_t[c] = -100; m_sp[c] = 0; m_dd[c] = 0;
    end
    rst_edge = n;
  endtask

  // Applies the rules for the upcoming edge e = n+1 using pre-edge state.
  task automatic model_edge();
    int e = n + 1;
    bit drop = 1'b0;
    bit clr = 1'b0;
    bit pin2;
    pin_log[e] = pin_shutdown;
    for (int c = 0; c < CH; c++) begin
      if (step_pulse[c] && !m_sd) begin
        if (busy_at(c, e - 1)) drop = 1'b1;
        else begin
          m_sp[c]  = (step_dir[c] != m_dir[c]) ? m_setup : 0;
          m_dir[c] = step_dir[c];
          m_t[c]   = e;
          m_dd[c]  = m_dur;
        end
      end
    end
    if (drop && m_ovr < 255) m_ovr++;
    if (wb_cyc_i && wb_stb_i && wb_we_i) begin
      case (wb_adr_i)
        4'd0: m_pol = wb_dat_i[2*CH-1:0];
        4'd1: clr = 1'b1;
        4'd2: m_dur = int'(wb_dat_i[DW-1:0]);
        4'd3: m_setup = int'(wb_dat_i[DW-1:0]);
        4'd4: m_ovr = 0;
        default: ;
      endcase
    end
    pin2 = (e - 2 > rst_edge) ? pin_log[e - 2] : 1'b0;
    m_sd = clr ? 1'b0 : (m_sd | pin2);
  endtask

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    model_edge();
    @(posedge clk);
    n++;
    @(negedge clk);
    chk($sformatf("pins@%0d", n), 32'(pins_out), exp_pins());
  endtask

  task automatic rd_chk(int adr, string tag);
    wb_adr_i = 4'(adr);
    #1;
    chk(tag, wb_dat_o, exp_reg(adr));
  endtask

  task automatic wr(int adr, logic [31:0] dat);
    wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = 1'b1;
    wb_adr_i = 4'(adr); wb_dat_i = dat;
    cyc();
    wb_cyc_i = 1'b0; wb_stb_i = 1'b0; wb_we_i = 1'b0;
    rd_chk(adr, $sformatf("rdback%0d", adr));
  endtask

  task automatic req(logic [CH-1:0] p, logic [CH-1:0] d);
    step_pulse = p; step_dir = d;
    cyc();
    step_pulse = '0;
  endtask

  initial begin
    int lo, hi, bz;
    model_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_pins", 32'(pins_out), 32'd0);
    chk("rst_ack", 32'(wb_ack_o), 32'd1);
    rst_n = 1'b1;
    for (int a = 0; a < 6; a++) rd_chk(a, $sformatf("rst_reg%0d", a));

    // Active-low step on ch0, 3 cycles.
    wr(0, 32'h5); wr(2, 32'd3); wr(3, 32'd0);
    lo = 0;
    req(2'b01, 2'b00);
    lo += !pins_out[0];
    chk("ch1_step_idle", 32'(pins_out[2]), 32'd1);
    repeat (5) begin
      cyc();
      lo += !pins_out[0];
      chk("ch1_step_idle", 32'(pins_out[2]), 32'd1);
    end
    chk("ch0_low_cycles", 32'(lo), 32'd3);

    // Direction change with setup delay on ch1.
    wr(0, 32'h0); wr(3, 32'd4); wr(2, 32'd2);
    hi = 0; bz = 0;
    req(2'b10, 2'b10);
    chk("ch1_dir_t1", 32'(pins_out[3]), 32'd1);
    rd_chk(1, "status_setup");
    hi += pins_out[2];
    bz += wb_dat_o[9];
    repeat (7) begin
      cyc();
      rd_chk(1, "status_run");
      hi += pins_out[2];
      bz += wb_dat_o[9];
    end
    chk("ch1_pulse_cycles", 32'(hi), 32'd2);
    chk("ch1_busy_cycles", 32'(bz), 32'd6);

    // Overrun: overlapping request, saturation, clear.
    wr(2, 32'd10); wr(3, 32'd0);
    req(2'b01, 2'b00);
    repeat (3) cyc();
    req(2'b01, 2'b00);
    rd_chk(4, "ovr_one");
    chk("ovr_one_abs", wb_dat_o, OVR_EN ? 32'd1 : 32'd0);
    repeat (12) cyc();
    step_pulse = 2'b01;
    repeat (300) cyc();
    step_pulse = '0;
    rd_chk(4, "ovr_sat");
    chk("ovr_sat_abs", wb_dat_o, OVR_EN ? 32'd255 : 32'd0);
    wr(4, 32'd0);
    repeat (12) cyc();

    // Loaded count is unaffected by a later duration write.
    req(2'b10, 2'b10);
    wr(2, 32'd2);
    repeat (10) cyc();

    // Shutdown mid-pulse, ignored requests, clear.
    wr(2, 32'd10);
    req(2'b01, 2'b00);
    cyc();
    pin_shutdown = 1'b1;
    repeat (3) cyc();
    rd_chk(1, "sd_set");
    chk("sd_bit0", 32'(wb_dat_o[0]), 32'd1);
    rd_chk(4, "sd_ovr_before");
    repeat (3) req(2'b11, 2'b01);
    rd_chk(4, "sd_ovr_after");
    pin_shutdown = 1'b0;
    repeat (4) cyc();
    wr(1, 32'd0);
    chk("sd_cleared", 32'(wb_dat_o[0]), 32'd0);
    repeat (10) cyc();

    // Zero duration: dir pin moves, step pin does not.
    wr(2, 32'd0);
    req(2'b01, 2'b01);
    chk("zd_dir", 32'(pins_out[1]), 32'd1);
    chk("zd_step", 32'(pins_out[0]), 32'd0);
    repeat (3) cyc();

    // Randomized traffic.
    for (int i = 0; i < 600; i++) begin
      if (all_idle() && $urandom_range(0, 9) == 0) begin
        int a = $urandom_range(0, 6);
        logic [31:0] d = $urandom();
        if (a == 2) d = $urandom_range(0, 5);
        if (a == 3) d = $urandom_range(0, 4);
        wr(a, d);
      end else begin
        if ($urandom_range(0, 59) == 0) pin_shutdown = ~pin_shutdown;
        step_pulse = ($urandom_range(0, 2) == 0) ? CH'($urandom_range(0, 3)) : '0;
        step_dir   = CH'($urandom_range(0, 3));
        cyc();
        step_pulse = '0;
        rd_chk($urandom_range(0, 5), $sformatf("rand_rd%0d", i));
      end
    end
    pin_shutdown = 1'b0;
    repeat (3) cyc();
    wr(1, 32'd0);
    repeat (12) cyc();

    // Asynchronous reset in the middle of a setup phase.
    wr(0, 32'hA); wr(3, 32'd5); wr(2, 32'd3);
    req(2'b01, ~m_dir[0] ? 2'b01 : 2'b00);
    cyc();
    rd_chk(1, "pre_rst_busy");
    #2 rst_n = 1'b0;
    #1 chk("async_rst_pins", 32'(pins_out), 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    model_reset();
    rst_n = 1'b1;
    for (int a = 0; a < 6; a++) rd_chk(a, $sformatf("post_rst_reg%0d", a));
    repeat (4) cyc();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pincfg_multi.md
# pincfg_multi

Multi-channel, parametrised successor to the single-channel output-pin configuration block. For each of `CHANNELS` stepper channels it generates a timed step pulse and a direction output. Each output pin has programmable polarity. A programmable direction-to-step setup delay is enforced, pulses are suppressed by a latched external shutdown, and overlapping step requests are counted. It sits between the step-timing engines and the chip output pins, and is configured over the shared Wishbone register bus.

## Interface
- `CHANNELS`, 2: number of step/dir channels; legal range 1..8.
- `DUR_WIDTH`, 16: width of the duration and setup counters; legal range 1..16.
- `clk` in 1: system clock.
- `rst_n` in 1: asynchronous, active-low reset. One clock; reset is asynchronous and active-low.
- `step_pulse` in CHANNELS: one-cycle step request per channel.
- `step_dir` in CHANNELS: requested direction per channel, sampled with `step_pulse`.
- `pins_out` out 2*CHANNELS: pin 2c is the step output of channel c; pin 2c+1 is the dir output of channel c.
- `pin_shutdown` in 1: asynchronous external shutdown request, active-high.
- `wb_stb_i`, `wb_cyc_i`, `wb_we_i` in 1 each: Wishbone strobe, cycle and write-enable.
- `wb_adr_i` in 4: register address.
- `wb_dat_i` in 32: write data.
- `wb_dat_o` out 32: read data.
- `wb_ack_o` out 1: acknowledge.

## Operation
- **Command qualifier:** a write is `wb_cyc_i && wb_stb_i && wb_we_i`.
- **Register map:**
  - Adr 0, polarity: bits [2*CHANNELS-1:0], read/write.
  - Adr 1, status: write = clear shutdown. Read: bit0 = `in_shutdown`; bits [8+c] = channel c is not IDLE.
  - Adr 2, `step_duration`: bits [DUR_WIDTH-1:0], read/write.
  - Adr 3, `dir_setup`: bits [DUR_WIDTH-1:0], read/write.
  - Adr 4, overrun count: bits [7:0]; any write clears it.
  - Other addresses: read 0; writes ignored.
  - Unused read bits: 0.
- **Per-channel state machine** (states IDLE, SETUP, PULSE; one `DUR_WIDTH` down-counter per channel):
  - IDLE, `step_pulse[c]` set, not in shutdown, `step_dir[c]` differs from `dir_q[c]`:
    - Load `dir_q[c] <= step_dir[c]`.
    - If `dir_setup != 0`: go to SETUP with count = `dir_setup`.
    - Otherwise: go to PULSE with count = `step_duration`.
  - IDLE, `step_pulse[c]` set, not in shutdown, direction unchanged: go to PULSE with count = `step_duration`.
  - Zero duration: if `step_duration == 0`, a transition into PULSE goes to IDLE instead. No pulse is produced.
  - SETUP: decrement the counter. When it reaches 1, go to PULSE with count = `step_duration` (same zero rule applies).
  - PULSE: decrement the counter. When it reaches 1, go to IDLE.
  - `step_pulse[c]` while not IDLE: the request is dropped and overrun increments. Overrun saturates at 255 and is shared across channels. If several channels overrun in one cycle, the count increments by 1.
  - `step_pulse[c]` while in shutdown: ignored and not counted. `dir_q` is unchanged.
- **Shutdown:**
  - `pin_shutdown` passes through a 2-flop synchroniser.
  - `in_shutdown` sets when the synchroniser output is 1.
  - A write to adr 1 clears `in_shutdown`. Clear wins a same-cycle conflict; if the pin is still high, `in_shutdown` sets again the next cycle.
  - While in shutdown, every step pin is held at its polarity bit. State machines already running finish normally but are invisible on the pins.
- **Outputs:**
  - `pins_out[2c] = polarity[2c] ^ (state_c == PULSE && !in_shutdown)`.
  - `pins_out[2c+1] = polarity[2c+1] ^ dir_q[c]`.

## Timing
- **Reset values:** all registers, `dir_q`, overrun, `in_shutdown` and the synchroniser flops are 0; all states are IDLE. Hence `pins_out = 0` and `wb_ack_o = 1`.
- **Reset mid-operation:** `pins_out` drops to 0 asynchronously, without waiting for a clock edge.
- **Wishbone:** `wb_ack_o` is constantly 1, so every access is single-cycle. `wb_dat_o` is combinational from `wb_adr_i` and register state. A register write takes effect at the next edge.
- **Pulse timing:** `step_pulse` sampled at edge t:
  - With no direction change, the step pin is active for cycles t+1 .. t+`step_duration`.
  - With a direction change, the dir pin changes at t+1. The step pin is active from t+1+`dir_setup` for `step_duration` cycles.
  - The channel accepts a new request at the edge where it is back in IDLE, i.e. one cycle after the last active cycle.
- **Duration changes:** changing `step_duration` or `dir_setup` does not affect a count already loaded.
- **Shutdown latency:** `in_shutdown` is set 3 edges after `pin_shutdown` rises (2 synchroniser edges + 1 latch edge). The step pin goes inactive in the same cycle `in_shutdown` sets.

## Configuration
- `PINCFG_OVERRUN_EN`:
  - Defined: the overrun counter at adr 4 is implemented as described.
  - Undefined: no counter logic is built; adr 4 reads 0 and writes to it are ignored. Dropped requests are still dropped.

## Test plan
- Reset, polarity=0x0005, `step_duration`=3, `dir_setup`=0, CHANNELS=2. Pulse ch0 with dir=0 -> `pins_out[0]` reads 0 for exactly 3 cycles; `pins_out[2]` stays 1.
- `dir_setup`=4, `step_duration`=2. Pulse ch1 with dir=1 -> `pins_out[3]` rises at t+1; `pins_out[2]` is high at t+5..t+6; status bit9 is 1 from t+1 to t+6.
- `step_duration`=10. Pulse ch0, then pulse ch0 again 4 cycles later -> the second request is ignored and adr 4 reads 1. 300 overlapping requests -> adr 4 reads 255. Write adr 4 -> reads 0.
- Raise `pin_shutdown` mid-pulse -> the step pin goes inactive 3 edges later and status bit0=1. Step requests while shut down -> no pins change, overrun unchanged. Drop the pin and write adr 1 -> bit0=0.
- `step_duration`=0 -> a step request produces no step pin activity, but the dir pin still updates.
- Assert `rst_n`=0 mid-SETUP -> `pins_out`=0 immediately. After release, all registers read 0.
